// File: rtl/iahb_mem_arb_if.sv
// Bus bundle for the two-master instruction-memory arbiter.
// The slave modport is the arbiter's view. The master modport is the
// view of the surrounding masters and the memory controller.
interface iahb_mem_arb_if;
    logic [31:0] m0_haddr;
    logic [1:0]  m0_htrans;
    logic [2:0]  m0_hsize;
    logic        m0_hwrite;
    logic [31:0] m0_hwdata;
    logic [31:0] m0_hrdata;
    logic        m0_hready;
    logic        m0_hresp;

    logic [31:0] m1_haddr;
    logic [1:0]  m1_htrans;
    logic [2:0]  m1_hsize;
    logic        m1_hwrite;
    logic [31:0] m1_hwdata;
    logic [31:0] m1_hrdata;
    logic        m1_hready;
    logic        m1_hresp;

    logic        lite_mmc_hsel;
    logic [31:0] lite_yy_haddr;
    logic [1:0]  lite_yy_htrans;
    logic [2:0]  lite_yy_hsize;
    logic        lite_yy_hwrite;
    logic [31:0] lite_yy_hwdata;
    logic [31:0] mmc_lite_hrdata;
    logic        mmc_lite_hready;
    logic        mmc_lite_hresp;

    modport slave (
        input  m0_haddr, m0_htrans, m0_hsize, m0_hwrite, m0_hwdata,
        output m0_hrdata, m0_hready, m0_hresp,
        input  m1_haddr, m1_htrans, m1_hsize, m1_hwrite, m1_hwdata,
        output m1_hrdata, m1_hready, m1_hresp,
        output lite_mmc_hsel, lite_yy_haddr, lite_yy_htrans, lite_yy_hsize,
        output lite_yy_hwrite, lite_yy_hwdata,
        input  mmc_lite_hrdata, mmc_lite_hready, mmc_lite_hresp
    );

    modport master (
        output m0_haddr, m0_htrans, m0_hsize, m0_hwrite, m0_hwdata,
        input  m0_hrdata, m0_hready, m0_hresp,
        output m1_haddr, m1_htrans, m1_hsize, m1_hwrite, m1_hwdata,
        input  m1_hrdata, m1_hready, m1_hresp,
        input  lite_mmc_hsel, lite_yy_haddr, lite_yy_htrans, lite_yy_hsize,
        input  lite_yy_hwrite, lite_yy_hwdata,
        output mmc_lite_hrdata, mmc_lite_hready, mmc_lite_hresp
    );
endinterface

// File: rtl/iahb_mem_arb.sv
// Two-master AHB-Lite arbiter with address decode and a local two-cycle
// ERROR responder for transfers that fall outside the memory window.
module iahb_mem_arb #(
    parameter logic [31:0] MEM_BASE = 32'h0000_0000,
    parameter int          MEM_AW   = 12
) (
    input  logic             pll_core_cpuclk,
    input  logic             pad_cpu_rst_b,
    iahb_mem_arb_if.slave    bus
);
    typedef enum logic {M0 = 1'b0, M1 = 1'b1} master_t;
    typedef enum logic [1:0] {DP_NONE, DP_MEM, DP_ERR} dp_kind_t;
    typedef enum logic [1:0] {E_IDLE, E1, E2} err_st_t;

    master_t  grant_reg, grant_next;
    master_t  dp_owner_reg, dp_owner_next;
    dp_kind_t dp_kind_reg, dp_kind_next;
    err_st_t  err_st_reg, err_st_next;

    logic [31:0] haddr_g;
    logic [1:0]  htrans_g;
    logic [2:0]  hsize_g;
    logic        hwrite_g;
    logic        req_g;
    logic        req_other;
    logic        in_win_g;
    logic        bus_ready;

    // Address-phase mux: the granted master drives the slave with no added latency.
    always_comb begin
        haddr_g   = bus.m0_haddr;
        htrans_g  = bus.m0_htrans;
        hsize_g   = bus.m0_hsize;
        hwrite_g  = bus.m0_hwrite;
        req_other = bus.m1_htrans[1];
        if (grant_reg == M1) begin
            haddr_g   = bus.m1_haddr;
            htrans_g  = bus.m1_htrans;
            hsize_g   = bus.m1_hsize;
            hwrite_g  = bus.m1_hwrite;
            req_other = bus.m0_htrans[1];
        end
    end

    assign req_g    = htrans_g[1];
    assign in_win_g = (haddr_g[31:MEM_AW] == MEM_BASE[31:MEM_AW]);

    assign bus.lite_yy_haddr  = haddr_g;
    assign bus.lite_yy_htrans = htrans_g;
    assign bus.lite_yy_hsize  = hsize_g;
    assign bus.lite_yy_hwrite = hwrite_g;
    assign bus.lite_mmc_hsel  = req_g && in_win_g;
    assign bus.lite_yy_hwdata = (dp_owner_reg == M1) ? bus.m1_hwdata : bus.m0_hwdata;

    // Data-phase completion: slave ready, the local error responder, or free.
    always_comb begin
        bus_ready = 1'b1;
        case (dp_kind_reg)
            DP_MEM:  bus_ready = bus.mmc_lite_hready;
            DP_ERR:  bus_ready = (err_st_reg == E2);
            default: bus_ready = 1'b1;
        endcase
    end

    // Per-master response: a waiting requester is stalled, only the owner sees hresp.
    always_comb begin
        bus.m0_hrdata = bus.mmc_lite_hrdata;
        bus.m1_hrdata = bus.mmc_lite_hrdata;
        bus.m0_hready = bus_ready && !(bus.m0_htrans[1] && grant_reg != M0);
        bus.m1_hready = bus_ready && !(bus.m1_htrans[1] && grant_reg != M1);
        bus.m0_hresp  = 1'b0;
        bus.m1_hresp  = 1'b0;
        if (dp_kind_reg == DP_MEM) begin
            if (dp_owner_reg == M0) bus.m0_hresp = bus.mmc_lite_hresp;
            else                    bus.m1_hresp = bus.mmc_lite_hresp;
        end else if (dp_kind_reg == DP_ERR) begin
            if (dp_owner_reg == M0) bus.m0_hresp = (err_st_reg != E_IDLE);
            else                    bus.m1_hresp = (err_st_reg != E_IDLE);
        end
    end

    // Next-state: phase advance only on bus_ready; the error FSM always leaves E1.
    always_comb begin
        grant_next    = grant_reg;
        dp_owner_next = dp_owner_reg;
        dp_kind_next  = dp_kind_reg;
        err_st_next   = err_st_reg;
        if (err_st_reg == E1) begin
            err_st_next = E2;
        end
        if (bus_ready) begin
            dp_owner_next = grant_reg;
            err_st_next   = E_IDLE;
            if (!req_g) begin
                dp_kind_next = DP_NONE;
            end else if (in_win_g) begin
                dp_kind_next = DP_MEM;
            end else begin
                dp_kind_next = DP_ERR;
                err_st_next  = E1;
            end
            // Bursts keep the grant; hand over only when the owner goes IDLE/BUSY.
            if (!req_g && req_other) begin
                grant_next = (grant_reg == M0) ? M1 : M0;
            end
        end
    end

    // State register with asynchronous active-low reset.
    always_ff @(posedge pll_core_cpuclk or negedge pad_cpu_rst_b) begin
        if (!pad_cpu_rst_b) begin
            grant_reg    <= M0;
            dp_owner_reg <= M0;
            dp_kind_reg  <= DP_NONE;
            err_st_reg   <= E_IDLE;
        end else begin
            grant_reg    <= grant_next;
            dp_owner_reg <= dp_owner_next;
            dp_kind_reg  <= dp_kind_next;
            err_st_reg   <= err_st_next;
        end
    end
endmodule

// File: tb/tb_iahb_mem_arb.sv
// Directed bench for iahb_mem_arb: the stimulus process queues the expected
// per-cycle response, a monitor pops and compares it on the falling edge.
module tb_iahb_mem_arb;
    localparam logic [1:0] IDLE = 2'b00;
    localparam logic [1:0] NS   = 2'b10;
    localparam logic [1:0] SEQ  = 2'b11;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    iahb_mem_arb_if bus_if ();

    iahb_mem_arb #(.MEM_BASE(32'h0000_0000), .MEM_AW(12)) dut (
        .pll_core_cpuclk (clk),
        .pad_cpu_rst_b   (rst_n),
        .bus             (bus_if)
    );

    typedef struct {
        string       name;
        logic        m0_rdy, m0_rsp, m1_rdy, m1_rsp, hsel;
        bit          c_addr; logic [31:0] addr;
        bit          c_rd;   logic [31:0] rd;
        bit          c_wd;   logic [31:0] wd;
        bit          c_wr;   logic        wr;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    function automatic exp_t mk(string n, logic a, logic b, logic c, logic d, logic e);
        exp_t x;
        x.name = n; x.m0_rdy = a; x.m0_rsp = b; x.m1_rdy = c; x.m1_rsp = d; x.hsel = e;
        x.c_addr = 0; x.addr = '0; x.c_rd = 0; x.rd = '0;
        x.c_wd = 0; x.wd = '0; x.c_wr = 0; x.wr = 1'b0;
        return x;
    endfunction
    function automatic exp_t wa(exp_t x, logic [31:0] a);
        x.c_addr = 1; x.addr = a; return x;
    endfunction
    function automatic exp_t wrd(exp_t x, logic [31:0] d);
        x.c_rd = 1; x.rd = d; return x;
    endfunction
    function automatic exp_t wwd(exp_t x, logic [31:0] d);
        x.c_wd = 1; x.wd = d; return x;
    endfunction
    function automatic exp_t wwr(exp_t x, logic w);
        x.c_wr = 1; x.wr = w; return x;
    endfunction

    task automatic cmp(string n, string f, logic [31:0] act, logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s.%s actual=%h required=%h", n, f, act, req);
        end
    endtask

    // Monitor: one queued expectation per cycle, compared mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                cmp(e.name, "m0_hready", {31'd0, bus_if.m0_hready}, {31'd0, e.m0_rdy});
                cmp(e.name, "m0_hresp",  {31'd0, bus_if.m0_hresp},  {31'd0, e.m0_rsp});
                cmp(e.name, "m1_hready", {31'd0, bus_if.m1_hready}, {31'd0, e.m1_rdy});
                cmp(e.name, "m1_hresp",  {31'd0, bus_if.m1_hresp},  {31'd0, e.m1_rsp});
                cmp(e.name, "hsel", {31'd0, bus_if.lite_mmc_hsel}, {31'd0, e.hsel});
                if (e.c_addr) cmp(e.name, "haddr", bus_if.lite_yy_haddr, e.addr);
                if (e.c_rd) begin
                    cmp(e.name, "m0_hrdata", bus_if.m0_hrdata, e.rd);
                    cmp(e.name, "m1_hrdata", bus_if.m1_hrdata, e.rd);
                end
                if (e.c_wd) cmp(e.name, "hwdata", bus_if.lite_yy_hwdata, e.wd);
                if (e.c_wr) cmp(e.name, "hwrite", {31'd0, bus_if.lite_yy_hwrite}, {31'd0, e.wr});
                $display("txn %-12s m0(rdy,rsp)=%b%b m1(rdy,rsp)=%b%b hsel=%b haddr=%h",
                         e.name, bus_if.m0_hready, bus_if.m0_hresp, bus_if.m1_hready,
                         bus_if.m1_hresp, bus_if.lite_mmc_hsel, bus_if.lite_yy_haddr);
            end
        end
    end

    task automatic set_m(input int m, input logic [1:0] tr, input logic [31:0] a,
                         input logic w, input logic [31:0] wd);
        if (m == 0) begin
            bus_if.m0_htrans = tr; bus_if.m0_haddr = a; bus_if.m0_hwrite = w; bus_if.m0_hwdata = wd;
        end else begin
            bus_if.m1_htrans = tr; bus_if.m1_haddr = a; bus_if.m1_hwrite = w; bus_if.m1_hwdata = wd;
        end
    endtask

    task automatic slv(input logic rdy, input logic rsp, input logic [31:0] rd);
        bus_if.mmc_lite_hready = rdy; bus_if.mmc_lite_hresp = rsp; bus_if.mmc_lite_hrdata = rd;
    endtask

    task automatic cyc(input exp_t e);
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus_if.m0_hsize = 3'b010;
        bus_if.m1_hsize = 3'b010;
        set_m(0, IDLE, 32'h0, 1'b0, 32'h0);
        set_m(1, IDLE, 32'h0, 1'b0, 32'h0);
        slv(1'b1, 1'b0, 32'h0);
        @(posedge clk);
        #1;
        cyc(mk("rst0", 1, 0, 1, 0, 0));
        cyc(mk("rst1", 1, 0, 1, 0, 0));
        rst_n = 1'b1;
        cyc(mk("post_rst", 1, 0, 1, 0, 0));

        // M0 single in-window read, zero-wait slave.
        set_m(0, NS, 32'h100, 1'b0, 32'h0);
        cyc(wa(mk("s1_addr", 1, 0, 1, 0, 1), 32'h100));
        set_m(0, IDLE, 32'h100, 1'b0, 32'h0);
        slv(1'b1, 1'b0, 32'hDEADBEEF);
        cyc(wrd(mk("s1_data", 1, 0, 1, 0, 0), 32'hDEADBEEF));

        // Simultaneous requests from the parked-on-M0 state.
        slv(1'b1, 1'b0, 32'h0);
        set_m(0, NS, 32'h200, 1'b0, 32'h0);
        set_m(1, NS, 32'h300, 1'b0, 32'h0);
        cyc(wa(mk("s2_c0", 1, 0, 0, 0, 1), 32'h200));
        set_m(0, IDLE, 32'h200, 1'b0, 32'h0);
        slv(1'b1, 1'b0, 32'h11111111);
        cyc(wrd(mk("s2_c1", 1, 0, 0, 0, 0), 32'h11111111));
        slv(1'b1, 1'b0, 32'h0);
        cyc(wa(mk("s2_c2", 1, 0, 1, 0, 1), 32'h300));
        set_m(1, IDLE, 32'h300, 1'b0, 32'h0);
        slv(1'b1, 1'b0, 32'h22222222);
        cyc(wrd(mk("s2_c3", 1, 0, 1, 0, 0), 32'h22222222));

        // M0 4-beat write burst while M1 waits (grant parked on M1 at start).
        slv(1'b1, 1'b0, 32'h0);
        set_m(0, NS, 32'h400, 1'b1, 32'h0);
        cyc(mk("s3_wait", 0, 0, 1, 0, 0));
        set_m(1, NS, 32'h500, 1'b0, 32'hBB);
        cyc(wwr(wa(mk("s3_b0", 1, 0, 0, 0, 1), 32'h400), 1'b1));
        set_m(0, SEQ, 32'h404, 1'b1, 32'hA0);
        cyc(wwd(wa(mk("s3_b1", 1, 0, 0, 0, 1), 32'h404), 32'hA0));
        set_m(0, SEQ, 32'h408, 1'b1, 32'hA1);
        cyc(wwd(wa(mk("s3_b2", 1, 0, 0, 0, 1), 32'h408), 32'hA1));
        set_m(0, SEQ, 32'h40C, 1'b1, 32'hA2);
        cyc(wwd(wa(mk("s3_b3", 1, 0, 0, 0, 1), 32'h40C), 32'hA2));
        set_m(0, IDLE, 32'h40C, 1'b1, 32'hA3);
        cyc(wwd(mk("s3_end", 1, 0, 0, 0, 0), 32'hA3));
        cyc(wa(mk("s3_m1", 1, 0, 1, 0, 1), 32'h500));
        set_m(1, IDLE, 32'h500, 1'b0, 32'hBB);
        slv(1'b1, 1'b0, 32'h33333333);
        cyc(wwd(wrd(mk("s3_m1_data", 1, 0, 1, 0, 0), 32'h33333333), 32'hBB));

        // M1 out-of-window write: local two-cycle ERROR, slave never selected.
        slv(1'b1, 1'b0, 32'h0);
        set_m(1, NS, 32'h1000_0000, 1'b1, 32'h0);
        cyc(wa(mk("s4_addr", 1, 0, 1, 0, 0), 32'h1000_0000));
        set_m(1, IDLE, 32'h1000_0000, 1'b1, 32'hCC);
        cyc(mk("s4_e1", 0, 0, 0, 1, 0));
        cyc(mk("s4_e2", 1, 0, 1, 1, 0));
        cyc(mk("s4_done", 1, 0, 1, 0, 0));

        // Slave stall during an M0 read while M1 is waiting.
        set_m(0, NS, 32'h600, 1'b0, 32'h0);
        cyc(mk("s5_wait", 0, 0, 1, 0, 0));
        cyc(wa(mk("s5_addr", 1, 0, 1, 0, 1), 32'h600));
        set_m(0, IDLE, 32'h600, 1'b0, 32'h0);
        set_m(1, NS, 32'h700, 1'b0, 32'h0);
        slv(1'b0, 1'b0, 32'h0);
        cyc(mk("s5_stall", 0, 0, 0, 0, 0));
        slv(1'b1, 1'b0, 32'hCAFEF00D);
        cyc(wrd(mk("s5_data", 1, 0, 0, 0, 0), 32'hCAFEF00D));
        slv(1'b1, 1'b0, 32'h0);
        cyc(wa(mk("s5_m1", 1, 0, 1, 0, 1), 32'h700));
        set_m(1, IDLE, 32'h700, 1'b0, 32'h0);
        cyc(mk("s5_m1_data", 1, 0, 1, 0, 0));

        // Reset asserted during the E1 cycle of an M1 error response.
        set_m(1, NS, 32'h2000_0000, 1'b0, 32'h0);
        cyc(wa(mk("s6_addr", 1, 0, 1, 0, 0), 32'h2000_0000));
        set_m(0, IDLE, 32'hABC0, 1'b0, 32'h0);
        set_m(1, NS, 32'h800, 1'b0, 32'h0);
        rst_n = 1'b0;
        cyc(wa(mk("s6_rst", 1, 0, 0, 0, 0), 32'hABC0));
        cyc(wa(mk("s6_hold", 1, 0, 0, 0, 0), 32'hABC0));
        rst_n = 1'b1;
        cyc(wa(mk("s6_rel", 1, 0, 0, 0, 0), 32'hABC0));
        cyc(wa(mk("s6_m1", 1, 0, 1, 0, 1), 32'h800));
        set_m(1, IDLE, 32'h800, 1'b0, 32'h0);
        cyc(mk("s6_end", 1, 0, 1, 0, 0));

        n_chk++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain actual=%0d required=0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
